// File: rtl/uart_word_packer.sv
// uart_word_packer
//   Packs the UART receive byte stream into WORD_BYTES-wide words with byte
//   strobes for the DDR AXI write path. A word is completed when its last lane
//   fills, on an explicit flush, or after FLUSH_TIMEOUT idle cycles with a
//   partial word pending. Completed words enter a small FIFO. When that FIFO is
//   full, one extra word is parked in a hold register and further bytes are
//   dropped until the word can be pushed.
//
// Ports
//   axi_clk       clock, all logic on the rising edge
//   i_rst         synchronous active-high reset
//   i_byte        received byte, qualified by i_byte_valid (no backpressure)
//   i_flush       emit the current partial word (ignored when nothing is assembled)
//   o_word        FIFO head word; stream byte k sits in bits [8k+7:8k]
//   o_strb        FIFO head byte strobes; bit k = lane k filled
//   o_word_valid  FIFO not empty
//   i_word_ready  consumer accepts the head word when o_word_valid is high
//   o_overflow    sticky flag, set when a byte is dropped; cleared only by reset
//   o_word_count  number of words pushed into the FIFO, wraps at 2^16
//   o_busy        partial word being assembled, or a word waiting in hold
module uart_word_packer #(
    parameter int WORD_BYTES    = 32,
    parameter int FIFO_DEPTH    = 2,
    parameter int FLUSH_TIMEOUT = 1024
) (
    input  logic                    axi_clk,
    input  logic                    i_rst,
    input  logic [7:0]              i_byte,
    input  logic                    i_byte_valid,
    input  logic                    i_flush,
    output logic [8*WORD_BYTES-1:0] o_word,
    output logic [WORD_BYTES-1:0]   o_strb,
    output logic                    o_word_valid,
    input  logic                    i_word_ready,
    output logic                    o_overflow,
    output logic [15:0]             o_word_count,
    output logic                    o_busy
);

    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int LANE_W = $clog2(WORD_BYTES + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int TMO_W  = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    // idleCnt holds the number of idle cycles already seen, so the current
    // idle cycle is the FLUSH_TIMEOUT-th one when idleCnt reaches TIMEOUT-1.
    localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'((FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT - 1 : 0);

    typedef enum logic {FILL, HOLD} state_t;

    state_t              state, stateNext;
    logic [LANE_W-1:0]   lanes;
    logic [WORD_W-1:0]   asmWord;
    logic [WORD_BYTES-1:0] asmStrb;
    logic [WORD_W-1:0]   holdWord;
    logic [WORD_BYTES-1:0] holdStrb;
    logic [TMO_W-1:0]    idleCnt;
    logic [WORD_W-1:0]   fifoWord [FIFO_DEPTH];
    logic [WORD_BYTES-1:0] fifoStrb [FIFO_DEPTH];
    logic [PTR_W-1:0]    wrPtr, rdPtr;
    logic [CNT_W-1:0]    fifoCnt;
    logic                overflow;
    logic [15:0]         wordCount;

    logic                pop, space, accept, flushEv, timeoutEv, complete;
    logic                pushFill, pushHold, toHold, push;
    logic [WORD_W-1:0]   mergedWord, pushWord;
    logic [WORD_BYTES-1:0] mergedStrb, pushStrb;

    // Completed word = assembly register with this cycle's byte merged in.
    always_comb begin
        mergedWord = asmWord;
        mergedStrb = asmStrb;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (accept && lanes == LANE_W'(k)) begin
                mergedWord[8*k +: 8] = i_byte;
                mergedStrb[k]        = 1'b1;
            end
        end
    end

    always_comb begin
        pop       = (fifoCnt != '0) && i_word_ready;
        // A same-cycle pop frees a slot, so a full FIFO can still take a push.
        space     = (fifoCnt < DEPTH_CNT) || pop;
        accept    = (state == FILL) && i_byte_valid;
        // A byte arriving with the flush counts as assembled content.
        flushEv   = i_flush && ((lanes != '0) || accept);
        timeoutEv = (FLUSH_TIMEOUT != 0) && !accept && (lanes != '0) && (idleCnt >= TMO_LIMIT);
        complete  = (state == FILL) && ((accept && lanes == LAST_LANE) || flushEv || timeoutEv);
        pushFill  = complete && space;
        toHold    = complete && !space;
        pushHold  = (state == HOLD) && space;
        push      = pushFill || pushHold;
        pushWord  = pushHold ? holdWord : mergedWord;
        pushStrb  = pushHold ? holdStrb : mergedStrb;
    end

    always_comb begin
        stateNext = state;
        if (toHold) begin
            stateNext = HOLD;
        end else if (pushHold) begin
            stateNext = FILL;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (i_rst) begin
            state <= FILL;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (i_rst) begin
            lanes     <= '0;
            asmWord   <= '0;
            asmStrb   <= '0;
            idleCnt   <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCnt   <= '0;
            overflow  <= 1'b0;
            wordCount <= '0;
        end else begin
            if (complete) begin
                lanes   <= '0;
                asmWord <= '0;
                asmStrb <= '0;
            end else if (accept) begin
                lanes   <= lanes + 1'b1;
                asmWord <= mergedWord;
                asmStrb <= mergedStrb;
            end

            if (accept || push || state == HOLD) begin
                idleCnt <= '0;
            end else if (lanes != '0 && idleCnt != '1) begin
                idleCnt <= idleCnt + 1'b1;
            end

            if (state == HOLD && i_byte_valid) begin
                overflow <= 1'b1;
            end

            if (push) begin
                wrPtr     <= (wrPtr == LAST_PTR) ? '0 : wrPtr + 1'b1;
                wordCount <= wordCount + 1'b1;
            end
            if (pop) begin
                rdPtr <= (rdPtr == LAST_PTR) ? '0 : rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifoCnt <= fifoCnt + 1'b1;
                2'b01:   fifoCnt <= fifoCnt - 1'b1;
                default: fifoCnt <= fifoCnt;
            endcase
        end
    end

    // Word storage carries no reset; occupancy is tracked by fifoCnt and state.
    always_ff @(posedge axi_clk) begin
        if (toHold) begin
            holdWord <= mergedWord;
            holdStrb <= mergedStrb;
        end
        if (push) begin
            fifoWord[wrPtr] <= pushWord;
            fifoStrb[wrPtr] <= pushStrb;
        end
    end

    assign o_word_valid = (fifoCnt != '0);
    assign o_word       = o_word_valid ? fifoWord[rdPtr] : '0;
    assign o_strb       = o_word_valid ? fifoStrb[rdPtr] : '0;
    assign o_overflow   = overflow;
    assign o_word_count = wordCount;
    assign o_busy       = (asmStrb != '0) || (state == HOLD);

endmodule

// File: tb/tb_uart_word_packer.sv
module tb_uart_word_packer;

    localparam int WB  = 32;
    localparam int FD  = 2;
    localparam int TMO = 16;

    logic           axi_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic [7:0]     i_byte = '0;
    logic           i_byte_valid = 1'b0;
    logic           i_flush = 1'b0;
    logic           i_word_ready = 1'b0;
    logic [255:0]   o_word;
    logic [31:0]    o_strb;
    logic           o_word_valid;
    logic           o_overflow;
    logic [15:0]    o_word_count;
    logic           o_busy;

    always #5 axi_clk = ~axi_clk;

    uart_word_packer #(
        .WORD_BYTES   (WB),
        .FIFO_DEPTH   (FD),
        .FLUSH_TIMEOUT(TMO)
    ) dut (
        .axi_clk     (axi_clk),
        .i_rst       (i_rst),
        .i_byte      (i_byte),
        .i_byte_valid(i_byte_valid),
        .i_flush     (i_flush),
        .o_word      (o_word),
        .o_strb      (o_strb),
        .o_word_valid(o_word_valid),
        .i_word_ready(i_word_ready),
        .o_overflow  (o_overflow),
        .o_word_count(o_word_count),
        .o_busy      (o_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: bytes of the word being assembled, words expected in the
    // output queue, and one parked word when the queue had no room.
    logic [7:0]   mBytes[$];
    logic [255:0] mOutW[$];
    logic [31:0]  mOutS[$];
    int           mIdle;
    bit           mHold;
    logic [255:0] mHoldW;
    logic [31:0]  mHoldS;
    bit           mOvf;
    logic [15:0]  mCount;

    task automatic packBytes(output logic [255:0] w, output logic [31:0] s);
        w = '0;
        s = '0;
        foreach (mBytes[k]) begin
            w[8*k +: 8] = mBytes[k];
            s[k]        = 1'b1;
        end
    endtask

    task automatic modelStep(input bit rst, input bit bv, input logic [7:0] b, input bit fl, input bit rdy);
        logic [255:0] w;
        logic [31:0]  s;
        bit pop, space, done;
        int idleNow;
        if (rst) begin
            mBytes.delete(); mOutW.delete(); mOutS.delete();
            mIdle = 0; mHold = 0; mOvf = 0; mCount = '0;
            return;
        end
        pop   = (mOutW.size() > 0) && rdy;
        space = (mOutW.size() < FD) || pop;
        if (pop) begin
            void'(mOutW.pop_front());
            void'(mOutS.pop_front());
        end
        if (mHold) begin
            if (bv) mOvf = 1;
            if (space) begin
                mOutW.push_back(mHoldW);
                mOutS.push_back(mHoldS);
                mCount++;
                mHold = 0;
            end
            mIdle = 0;
        end else begin
            if (bv) mBytes.push_back(b);
            idleNow = bv ? 0 : ((mBytes.size() > 0) ? mIdle + 1 : 0);
            done = (bv && mBytes.size() == WB) || (fl && mBytes.size() > 0) || (idleNow == TMO);
            if (done) begin
                packBytes(w, s);
                mBytes.delete();
                mIdle = 0;
                if (space) begin
                    mOutW.push_back(w);
                    mOutS.push_back(s);
                    mCount++;
                end else begin
                    mHold  = 1;
                    mHoldW = w;
                    mHoldS = s;
                end
            end else begin
                mIdle = idleNow;
            end
        end
    endtask

    task automatic checkAll();
        chkVal("valid", o_word_valid, mOutW.size() > 0);
        if (mOutW.size() > 0) begin
            chkVal("word", o_word, mOutW[0]);
            chkVal("strb", o_strb, mOutS[0]);
        end
        chkVal("overflow", o_overflow, mOvf);
        chkVal("count", o_word_count, mCount);
        chkVal("busy", o_busy, (mBytes.size() > 0) || mHold);
    endtask

    // Apply one cycle of inputs, advance the model, then check just after the edge.
    task automatic step(input bit rst, input bit bv, input logic [7:0] b, input bit fl, input bit rdy);
        i_rst        = rst;
        i_byte_valid = bv;
        i_byte       = b;
        i_flush      = fl;
        i_word_ready = rdy;
        modelStep(rst, bv, b, fl, rdy);
        @(posedge axi_clk);
        #1;
        checkAll();
    endtask

    initial begin
        logic [255:0] expW;
        int lane0s[$];
        int dens, flp, rdp;

        // Reset state
        step(1, 0, 8'h00, 0, 1);
        step(1, 0, 8'h00, 0, 1);
        chkVal("rst_word", o_word, '0);
        chkVal("rst_strb", o_strb, '0);
        chkVal("rst_valid", o_word_valid, 1'b0);
        chkVal("rst_count", o_word_count, 16'd0);
        chkVal("rst_busy", o_busy, 1'b0);

        // T1 full word
        expW = '0;
        for (int i = 0; i < 32; i++) begin
            step(0, 1, 8'(i), 0, 1);
            expW[8*i +: 8] = 8'(i);
            if (i == 30) chkVal("t1_early", o_word_valid, 1'b0);
        end
        chkVal("t1_valid", o_word_valid, 1'b1);
        chkVal("t1_word", o_word, expW);
        chkVal("t1_strb", o_strb, 32'hFFFF_FFFF);
        chkVal("t1_count", o_word_count, 16'd1);
        step(0, 0, 8'h00, 0, 1);

        // T2 partial flush
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'hA0 + i), 0, 1);
        step(0, 0, 8'h00, 1, 1);
        chkVal("t2_word", o_word, 256'h00A4A3A2A1A0);
        chkVal("t2_strb", o_strb, 32'h0000_001F);
        step(0, 0, 8'h00, 0, 1);

        // T3 idle timeout
        for (int i = 0; i < 3; i++) step(0, 1, 8'(8'hC0 + i), 0, 1);
        for (int i = 0; i < 15; i++) step(0, 0, 8'h00, 0, 1);
        chkVal("t3_no_early", o_word_valid, 1'b0);
        step(0, 0, 8'h00, 0, 1);
        chkVal("t3_valid", o_word_valid, 1'b1);
        chkVal("t3_strb", o_strb, 32'h0000_0007);
        step(0, 0, 8'h00, 0, 1);

        // T4 backpressure into hold, then drain in order
        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 100; i++) step(0, 1, 8'(i), 0, 0);
        chkVal("t4_overflow", o_overflow, 1'b1);
        chkVal("t4_busy_hold", o_busy, 1'b1);
        chkVal("t4_count2", o_word_count, 16'd2);
        for (int i = 0; i < 8; i++) begin
            if (o_word_valid) lane0s.push_back(int'(o_word[7:0]));
            step(0, 0, 8'h00, 0, 1);
        end
        chkVal("t4_nwords", lane0s.size(), 3);
        foreach (lane0s[i]) chkVal("t4_order", lane0s[i], 32 * i);
        chkVal("t4_count3", o_word_count, 16'd3);

        // T5 reset mid-word
        for (int i = 0; i < 10; i++) step(0, 1, 8'(8'h10 + i), 0, 1);
        step(1, 0, 8'h00, 0, 1);
        chkVal("t5_rst_busy", o_busy, 1'b0);
        for (int i = 0; i < 32; i++) step(0, 1, 8'(8'h40 + i), 0, 1);
        chkVal("t5_strb", o_strb, 32'hFFFF_FFFF);
        chkVal("t5_lane0", o_word[7:0], 8'h40);
        chkVal("t5_count", o_word_count, 16'd1);
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 1);
        chkVal("t5_one_word", o_word_valid, 1'b0);

        // T6 corner flushes
        step(0, 0, 8'h00, 1, 1);
        chkVal("t6_empty_flush", o_word_valid, 1'b0);
        chkVal("t6_empty_count", o_word_count, 16'd1);
        for (int i = 0; i < 31; i++) step(0, 1, 8'(8'h60 + i), 0, 1);
        step(0, 1, 8'h7F, 1, 1);
        chkVal("t6_full_strb", o_strb, 32'hFFFF_FFFF);
        chkVal("t6_full_count", o_word_count, 16'd2);
        step(0, 0, 8'h00, 0, 1);
        chkVal("t6_single", o_word_valid, 1'b0);
        chkVal("t6_not_busy", o_busy, 1'b0);

        // Randomized traffic with varying density, flush and ready rates
        step(1, 0, 8'h00, 0, 1);
        dens = 50; flp = 3; rdp = 70;
        for (int c = 0; c < 4000; c++) begin
            if (c % 150 == 0) begin
                dens = $urandom_range(100, 0);
                flp  = $urandom_range(8, 0);
                rdp  = $urandom_range(100, 0);
            end
            step(($urandom_range(999, 0) == 0),
                 ($urandom_range(99, 0) < dens),
                 8'($urandom),
                 ($urandom_range(99, 0) < flp),
                 ($urandom_range(99, 0) < rdp));
        end
        for (int c = 0; c < 60; c++) step(0, 0, 8'h00, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
